// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches the word at PC over a
// level req/ack instruction-memory handshake and aborts hung fetches.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        pc_we,
    input  logic [15:0] next_pc,
    output logic [15:0] PC,
    output logic [15:0] IR,
    output logic        ins_valid,
    output logic        busy,
    output logic        fetch_err,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata
);

    localparam int unsigned        W       = 16;
    localparam int unsigned        CNT_W   = 16;
    localparam bit                 TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0]   TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     pc_q, pc_d;
    logic [W-1:0]     ir_q, ir_d;
    logic [W-1:0]     addr_q, addr_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             timeout_hit_c;

    // Final wait cycle of an unanswered request; an ack in this cycle still wins.
    assign timeout_hit_c = TO_EN && (cnt_q == TO_LAST);

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next-state: start on fetch_req, finish on ack or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_req) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack || timeout_hit_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, counter and datapath registers.
    always_comb begin
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        req_d   = (state_d == S_REQ);
        busy_d  = (state_d == S_REQ);
        pc_d    = pc_we ? next_pc : pc_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_req) begin
                    addr_d = pc_q;
                    cnt_d  = '0;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    valid_d = 1'b1;
                end else if (timeout_hit_c) begin
                    err_d = 1'b1;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign PC        = pc_q;
    assign IR        = ir_q;
    assign ins_valid = valid_q;
    assign busy      = busy_q;
    assign fetch_err = err_q;
    assign imem_req  = req_q;
    assign imem_addr = addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a driver acts as control FSM and
// instruction memory, a monitor checks every fetch outcome against a queue.
module tb_instr_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0100;
    localparam int          TIMEOUT  = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic        pc_we;
    logic [15:0] next_pc;
    logic [15:0] PC;
    logic [15:0] IR;
    logic        ins_valid;
    logic        busy;
    logic        fetch_err;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .pc_we      (pc_we),
        .next_pc    (next_pc),
        .PC         (PC),
        .IR         (IR),
        .ins_valid  (ins_valid),
        .busy       (busy),
        .fetch_err  (fetch_err),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata)
    );

    always #5 clk = ~clk;

    // One expected fetch outcome.
    typedef struct {
        logic [15:0] addr;
        bit          ok;
        logic [15:0] data;
        int          nreq;
    } exp_t;

    exp_t        q[$];
    int          tests  = 0;
    int          failed = 0;
    bit          mon_en = 1'b0;
    logic [15:0] pc_model;
    logic [15:0] ir_model;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural PC: reset value, else whatever the control side last wrote.
    always @(posedge clk) begin
        if (rst) pc_model <= RESET_PC;
        else if (pc_we) pc_model <= next_pc;
    end

    // Monitor: per-cycle PC/request checks, pops the scoreboard on each outcome.
    initial begin
        int   req_cnt;
        bit   last_req;
        exp_t it;
        req_cnt  = 0;
        last_req = 1'b0;
        ir_model = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst) begin
                ir_model = 16'h0000;
                req_cnt  = 0;
                last_req = 1'b0;
            end else if (mon_en) begin
                chk("pc", PC, pc_model);
                if (imem_req) begin
                    req_cnt++;
                    chk("busy_in_req", busy, 1);
                    if (q.size() == 0) chk("req_unexpected", imem_req, 0);
                    else chk("imem_addr", imem_addr, q[0].addr);
                end
                if (ins_valid || fetch_err) begin
                    if (q.size() == 0) begin
                        chk("unexpected_event", {ins_valid, fetch_err}, 0);
                    end else begin
                        it = q.pop_front();
                        chk("ins_valid", ins_valid, it.ok);
                        chk("fetch_err", fetch_err, !it.ok);
                        chk("req_cycles", req_cnt, it.nreq);
                        chk("event_latency", last_req, 1);
                        chk("req_dropped", imem_req, 0);
                        chk("busy_dropped", busy, 0);
                        chk("ir", IR, it.ok ? it.data : ir_model);
                        if (it.ok) ir_model = it.data;
                    end
                    req_cnt = 0;
                end
                last_req = imem_req;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_clear();
        fetch_req  = 1'b0;
        pc_we      = 1'b0;
        next_pc    = 16'h0000;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
    endtask

    // One fetch: ack in req cycle d (never if d >= TIMEOUT); we_at: -2 none,
    // -1 in the fetch_req cycle, c>=0 in req cycle c. fr_mode: 0 low, 1 held, 2 random.
    task automatic run_fetch(input int d, input logic [15:0] data, input int we_at,
                             input logic [15:0] we_val, input bit we_inc, input int fr_mode);
        exp_t it;
        bit   ok;
        int   nreq;
        ok   = (d < TIMEOUT);
        nreq = ok ? d + 1 : TIMEOUT;
        step();
        drive_clear();
        fetch_req = 1'b1;
        if (we_at == -1) begin
            pc_we   = 1'b1;
            next_pc = we_val;
        end
        it.addr = pc_model;
        it.ok   = ok;
        it.data = data;
        it.nreq = nreq;
        q.push_back(it);
        for (int c = 0; c < nreq; c++) begin
            step();
            drive_clear();
            if (fr_mode == 1) fetch_req = 1'b1;
            else if (fr_mode == 2) fetch_req = 1'($urandom);
            if (c == d) begin
                imem_ack   = 1'b1;
                imem_rdata = data;
            end
            if (c == we_at) begin
                pc_we   = 1'b1;
                next_pc = we_inc ? pc_model + 16'd1 : we_val;
            end else if (fr_mode == 2 && we_at == -2 && $urandom_range(0, 3) == 0) begin
                pc_we   = 1'b1;
                next_pc = 16'($urandom);
            end
        end
    endtask

    // Idle cycles; with noise, stray acks and PC writes are thrown in.
    task automatic idle(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            step();
            drive_clear();
            if (noise) begin
                imem_ack   = 1'($urandom);
                imem_rdata = 16'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    pc_we   = 1'b1;
                    next_pc = 16'($urandom);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t it;
        rst = 1'b1;
        drive_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pc", PC, RESET_PC);
        chk("rst_ir", IR, 16'h0000);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_req", imem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {ins_valid, fetch_err}, 0);
        mon_en = 1'b1;

        // Zero-wait memory.
        run_fetch(0, 16'hA5C3, -2, 16'h0, 1'b0, 0);
        idle(1, 1'b0);
        // Slow memory, PC rewritten mid-fetch; address must stay latched.
        run_fetch(5, 16'h3C5A, 1, 16'h0101, 1'b0, 0);
        idle(1, 1'b0);
        // Timeout, then a late ack that must be ignored.
        run_fetch(TIMEOUT + 3, 16'h1234, -2, 16'h0, 1'b0, 0);
        step(); drive_clear();
        step(); drive_clear();
        imem_ack   = 1'b1;
        imem_rdata = 16'hDEAD;
        idle(2, 1'b0);
        // Ack in the last timeout cycle wins.
        run_fetch(TIMEOUT - 1, 16'h7E81, -2, 16'h0, 1'b0, 0);
        idle(1, 1'b0);
        // Back-to-back fetches with fetch_req held and PC+1 written on each ack.
        step(); drive_clear();
        pc_we   = 1'b1;
        next_pc = 16'h0000;
        for (int k = 0; k < 3; k++) run_fetch(1, 16'($urandom), 1, 16'h0, 1'b1, 1);
        idle(1, 1'b0);
        chk("b2b_pc", pc_model, 16'h0003);
        // PC write in the same cycle as fetch_req: the old PC is fetched.
        run_fetch(2, 16'h0F0F, -1, 16'h4444, 1'b0, 0);
        idle(1, 1'b0);

        // Reset in the second req cycle together with an ack.
        step(); drive_clear();
        fetch_req = 1'b1;
        it.addr = pc_model; it.ok = 1'b1; it.data = 16'hBEEF; it.nreq = 2;
        q.push_back(it);
        step(); drive_clear();
        step(); drive_clear();
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        q.delete();
        step(); drive_clear();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ir", IR, 16'h0000);
        chk("rstmid_pc", PC, RESET_PC);
        chk("rstmid_req", imem_req, 0);
        chk("rstmid_pulses", {ins_valid, fetch_err}, 0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            run_fetch(int'($urandom_range(0, TIMEOUT + 1)), 16'($urandom), -2, 16'h0, 1'b0, 2);
            idle(int'($urandom_range(0, 2)), 1'b1);
        end
        idle(3, 1'b0);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
